// File: rtl/multicycle_control_fsm.sv
// Multi-cycle Moore control sequencer for the RISC-V lab datapath.
// Optional I-type ALU group is built when MC_ITYPE_EN is defined.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        ADDR   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WB = 4'd5,
        MEM_WR = 4'd6,
        EXEC_R = 4'd7,
        ALU_WB = 4'd8,
        BRANCH = 4'd9,
        EXEC_I = 4'd10
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
`ifdef MC_ITYPE_EN
    localparam logic [6:0] OP_I  = 7'b0010011;
`endif

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_FUNCT = 2'b10;

    state_t state_q;
    state_t state_d;

    logic is_r;
    logic is_mem;
    logic is_br;
    logic is_i;
    logic is_legal;

    // Opcode classification, only consumed while in DECODE
    always_comb begin
        is_r   = (Opcode == OP_R);
        is_mem = (Opcode == OP_LD) || (Opcode == OP_SD);
        is_br  = (Opcode == OP_BR);
`ifdef MC_ITYPE_EN
        is_i   = (Opcode == OP_I);
`else
        is_i   = 1'b0;
`endif
        is_legal = is_r || is_mem || is_br || is_i;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                unique case (1'b1)
                    is_r:    state_d = EXEC_R;
                    is_mem:  state_d = ADDR;
                    is_br:   state_d = BRANCH;
`ifdef MC_ITYPE_EN
                    is_i:    state_d = EXEC_I;
`endif
                    default: state_d = FETCH;
                endcase
            end
            ADDR: begin
                // bit 5 separates sd from ld; IR keeps it stable
                state_d = Opcode[5] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                state_d = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                state_d = FETCH;
            end
            MEM_WR: begin
                state_d = mem_ready ? FETCH : MEM_WR;
            end
            EXEC_R: begin
                state_d = ALU_WB;
            end
            ALU_WB: begin
                state_d = FETCH;
            end
            BRANCH: begin
                state_d = FETCH;
            end
`ifdef MC_ITYPE_EN
            EXEC_I: begin
                state_d = ALU_WB;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs; mem_ready qualifiers and illegal_op are the exceptions
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = OP_ADD;
        PCSource    = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_4;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                // PC + imm lands in ALUOut as the branch target
                ALUSrcB    = SRCB_IMM;
                illegal_op = ~is_legal;
            end
            ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = OP_FUNCT;
            end
            ALU_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = OP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                instr_done  = 1'b1;
            end
`ifdef MC_ITYPE_EN
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = OP_FUNCT;
            end
`endif
            default: begin
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected
// state/outputs are queued with the stimulus and compared cycle by cycle.
module tb_multicycle_control_fsm;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_ADDR   = 4'd3;
    localparam logic [3:0] S_MEM_RD = 4'd4;
    localparam logic [3:0] S_MEM_WB = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_EXEC_R = 4'd7;
    localparam logic [3:0] S_ALU_WB = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_EXEC_I = 4'd10;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BAD = 7'b0000000;

`ifdef MC_ITYPE_EN
    localparam logic ITYPE = 1'b1;
`else
    localparam logic ITYPE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IRWrite, IorD;
    logic       MemRead, MemWrite, MemtoReg, RegWrite;
    logic       ALUSrcA, PCSource, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegWrite,
    //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource,instr_done,illegal_op}
    logic [15:0] obs;
    assign obs = {PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite,
                  MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  instr_done, illegal_op};

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        mr;
        logic        chk;
        logic [3:0]  st;
        logic [15:0] outs;
    } ent_t;

    ent_t q[$];

    // Output table written from the state descriptions
    function automatic logic [15:0] exp_out(input logic [3:0] st,
                                            input logic mr,
                                            input logic ill);
        logic [15:0] o;
        o = '0;
        case (st)
            S_FETCH:  begin o[15] = mr; o[13] = mr; o[11] = 1'b1; o[6:5] = 2'b01; end
            S_DECODE: begin o[6:5] = 2'b10; o[0] = ill; end
            S_ADDR:   begin o[7] = 1'b1; o[6:5] = 2'b10; end
            S_MEM_RD: begin o[12] = 1'b1; o[11] = 1'b1; end
            S_MEM_WB: begin o[9] = 1'b1; o[8] = 1'b1; o[1] = 1'b1; end
            S_MEM_WR: begin o[12] = 1'b1; o[10] = 1'b1; o[1] = mr; end
            S_EXEC_R: begin o[7] = 1'b1; o[4:3] = 2'b10; end
            S_ALU_WB: begin o[8] = 1'b1; o[1] = 1'b1; end
            S_BRANCH: begin
                o[14] = 1'b1; o[7] = 1'b1; o[4:3] = 2'b01;
                o[2] = 1'b1; o[1] = 1'b1;
            end
            S_EXEC_I: begin o[7] = 1'b1; o[6:5] = 2'b10; o[4:3] = 2'b10; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input logic rst, input logic [6:0] op, input logic mr,
                        input logic [3:0] st, input logic ill,
                        input logic chk);
        ent_t e;
        e.rst  = rst;
        e.op   = op;
        e.mr   = mr;
        e.chk  = chk;
        e.st   = st;
        e.outs = exp_out(st, mr, ill);
        q.push_back(e);
    endtask

    // Pops the next entry, drives its inputs, and waits into the cycle
    task automatic apply(output ent_t e);
        e = q.pop_front();
        @(negedge clk);
        reset     = e.rst;
        Opcode    = e.op;
        mem_ready = e.mr;
        #2;
    endtask

    task automatic test_reset();
        ent_t e;
        push(1'b1, OP_R, 1'b0, S_IDLE, 1'b0, 1'b0);
        push(1'b1, OP_R, 1'b1, S_IDLE, 1'b0, 1'b0);
        push(1'b0, OP_R, 1'b1, S_IDLE, 1'b0, 1'b1);
        while (q.size() > 0) begin
            apply(e);
            if (e.chk) begin
                checks++;
                if (state !== e.st) begin
                    failures++;
                    $display("FAIL reset_state got=%0d exp=%0d", state, e.st);
                end
                checks++;
                if (obs !== e.outs) begin
                    failures++;
                    $display("FAIL reset_outs got=%h exp=%h", obs, e.outs);
                end
            end
        end
    endtask

    task automatic test_rtype();
        ent_t e;
        push(1'b0, OP_R, 1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_R, 1'b1, S_DECODE, 1'b0, 1'b1);
        push(1'b0, OP_R, 1'b0, S_EXEC_R, 1'b0, 1'b1);
        push(1'b0, OP_R, 1'b1, S_ALU_WB, 1'b0, 1'b1);
        while (q.size() > 0) begin
            apply(e);
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL rtype_state got=%0d exp=%0d", state, e.st);
            end
            checks++;
            if (obs !== e.outs) begin
                failures++;
                $display("FAIL rtype_outs st=%0d got=%h exp=%h", e.st, obs, e.outs);
            end
        end
    endtask

    task automatic test_ld_wait();
        ent_t e;
        push(1'b0, OP_LD, 1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_LD, 1'b0, S_DECODE, 1'b0, 1'b1);
        push(1'b0, OP_LD, 1'b1, S_ADDR,   1'b0, 1'b1);
        push(1'b0, OP_LD, 1'b0, S_MEM_RD, 1'b0, 1'b1);
        push(1'b0, OP_LD, 1'b0, S_MEM_RD, 1'b0, 1'b1);
        push(1'b0, OP_LD, 1'b1, S_MEM_RD, 1'b0, 1'b1);
        push(1'b0, OP_LD, 1'b0, S_MEM_WB, 1'b0, 1'b1);
        while (q.size() > 0) begin
            apply(e);
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL ld_state got=%0d exp=%0d", state, e.st);
            end
            checks++;
            if (obs !== e.outs) begin
                failures++;
                $display("FAIL ld_outs st=%0d got=%h exp=%h", e.st, obs, e.outs);
            end
        end
    endtask

    task automatic test_sd();
        ent_t e;
        push(1'b0, OP_SD, 1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_SD, 1'b1, S_DECODE, 1'b0, 1'b1);
        push(1'b0, OP_SD, 1'b0, S_ADDR,   1'b0, 1'b1);
        push(1'b0, OP_SD, 1'b0, S_MEM_WR, 1'b0, 1'b1);
        push(1'b0, OP_SD, 1'b1, S_MEM_WR, 1'b0, 1'b1);
        while (q.size() > 0) begin
            apply(e);
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL sd_state got=%0d exp=%0d", state, e.st);
            end
            checks++;
            if (obs !== e.outs) begin
                failures++;
                $display("FAIL sd_outs st=%0d got=%h exp=%h", e.st, obs, e.outs);
            end
        end
    endtask

    task automatic test_beq();
        ent_t e;
        push(1'b0, OP_BR, 1'b0, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_BR, 1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_BR, 1'b1, S_DECODE, 1'b0, 1'b1);
        push(1'b0, OP_BR, 1'b0, S_BRANCH, 1'b0, 1'b1);
        while (q.size() > 0) begin
            apply(e);
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL beq_state got=%0d exp=%0d", state, e.st);
            end
            checks++;
            if (obs !== e.outs) begin
                failures++;
                $display("FAIL beq_outs st=%0d got=%h exp=%h", e.st, obs, e.outs);
            end
        end
    endtask

    task automatic test_illegal_itype();
        ent_t e;
        push(1'b0, OP_BAD, 1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_BAD, 1'b1, S_DECODE, 1'b1, 1'b1);
        push(1'b0, OP_I,   1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_I,   1'b1, S_DECODE, ~ITYPE, 1'b1);
        if (ITYPE) begin
            push(1'b0, OP_I, 1'b0, S_EXEC_I, 1'b0, 1'b1);
            push(1'b0, OP_I, 1'b1, S_ALU_WB, 1'b0, 1'b1);
        end
        while (q.size() > 0) begin
            apply(e);
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL illegal_itype_state got=%0d exp=%0d", state, e.st);
            end
            checks++;
            if (obs !== e.outs) begin
                failures++;
                $display("FAIL illegal_itype_outs st=%0d got=%h exp=%h",
                         e.st, obs, e.outs);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        ent_t e;
        push(1'b0, OP_SD, 1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_SD, 1'b1, S_DECODE, 1'b0, 1'b1);
        push(1'b0, OP_SD, 1'b1, S_ADDR,   1'b0, 1'b1);
        push(1'b1, OP_SD, 1'b0, S_MEM_WR, 1'b0, 1'b1);
        push(1'b0, OP_SD, 1'b1, S_IDLE,   1'b0, 1'b1);
        push(1'b0, OP_R,  1'b0, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_R,  1'b1, S_FETCH,  1'b0, 1'b1);
        push(1'b0, OP_R,  1'b1, S_DECODE, 1'b0, 1'b1);
        push(1'b0, OP_R,  1'b1, S_EXEC_R, 1'b0, 1'b1);
        while (q.size() > 0) begin
            apply(e);
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL rst_midwr_state got=%0d exp=%0d", state, e.st);
            end
            checks++;
            if (obs !== e.outs) begin
                failures++;
                $display("FAIL rst_midwr_outs st=%0d got=%h exp=%h",
                         e.st, obs, e.outs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ld_wait();
        test_sd();
        test_beq();
        test_illegal_itype();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
